// File: rtl/cpu_regfile_seq_if.sv
// Control-unit <-> register-file bundle: reads, writes, pair unit, PC/flags and the phase sequencer.
// With REGFILE_SNAPSHOT_EN defined, the shadow-bank save/restore strobes are added.
interface cpu_regfile_seq_if #(
    parameter int NUM_REGS = 14,
    parameter int REG_W    = 8,
    parameter int RD_PORTS = 2,
    parameter int PHASES   = 4
);
    localparam int IW  = $clog2(NUM_REGS);
    localparam int PW  = 2 * REG_W;
    localparam int PHW = $clog2(PHASES);

    logic                      stall;
    logic [PHW-1:0]            phase;
    logic                      commit;
    logic [RD_PORTS*IW-1:0]    rd_idx;
    logic [RD_PORTS*REG_W-1:0] rd_data;
    logic                      wr_en;
    logic [IW-1:0]             wr_idx;
    logic [REG_W-1:0]          wr_data;
    logic [1:0]                pair_op;
    logic [IW-1:0]             pair_hi;
    logic [IW-1:0]             pair_lo;
    logic [PW-1:0]             pair_out;
    logic [1:0]                pc_op;
    logic [PW-1:0]             pc_load;
    logic                      flag_en;
    logic [REG_W-1:0]          flag_data;
    logic [PW-1:0]             pc;
    logic [REG_W-1:0]          flags;
`ifdef REGFILE_SNAPSHOT_EN
    logic                      snap_save;
    logic                      snap_restore;
`endif

    modport master (
`ifdef REGFILE_SNAPSHOT_EN
        output snap_save, output snap_restore,
`endif
        output stall, rd_idx, wr_en, wr_idx, wr_data, pair_op, pair_hi, pair_lo,
        output pc_op, pc_load, flag_en, flag_data,
        input  phase, commit, rd_data, pair_out, pc, flags
    );

    modport slave (
`ifdef REGFILE_SNAPSHOT_EN
        input  snap_save, input snap_restore,
`endif
        input  stall, rd_idx, wr_en, wr_idx, wr_data, pair_op, pair_hi, pair_lo,
        input  pc_op, pc_load, flag_en, flag_data,
        output phase, commit, rd_data, pair_out, pc, flags
    );
endinterface

// File: rtl/cpu_regfile_seq.sv
// SM83-style register file with T-cycle sequencer and 16-bit pair inc/dec; reads and pair_out are
// combinational, all writes land on the commit edge; stall freezes the phase and holds off commit. Option: REGFILE_SNAPSHOT_EN.
module cpu_regfile_seq #(
    parameter int                          NUM_REGS   = 14,
    parameter int                          REG_W      = 8,
    parameter int                          RD_PORTS   = 2,
    parameter int                          PHASES     = 4,
    parameter int                          FLAG_IDX   = 6,
    parameter logic [REG_W-1:0]            FLAG_MASK  = 8'hF0,
    parameter int                          PC_HI_IDX  = 12,
    parameter logic [NUM_REGS*REG_W-1:0]   RESET_VALS = 112'h0001_0000_FEFF_01B0_4D01_D800_1300
) (
    input  logic               clk,
    input  logic               reset_n,
    cpu_regfile_seq_if.slave   bus
);
    localparam int IW  = $clog2(NUM_REGS);
    localparam int PW  = 2 * REG_W;
    localparam int PHW = $clog2(PHASES);
    localparam logic [IW:0]    NREGS      = (IW+1)'(NUM_REGS);
    localparam logic [PHW-1:0] LAST_PHASE = PHW'(PHASES - 1);

    typedef logic [REG_W-1:0] reg_t;

    reg_t           regs [NUM_REGS];
    reg_t           nxt  [NUM_REGS];
    logic [PHW-1:0] phase_q;
    logic [PW-1:0]  pair_in;
    logic [PW-1:0]  pair_out;
    reg_t           pair_hi_byte;
    reg_t           pair_lo_byte;
`ifdef REGFILE_SNAPSHOT_EN
    reg_t           shadow [NUM_REGS];
`endif

    function automatic logic in_range(input logic [IW-1:0] idx);
        return {1'b0, idx} < NREGS;
    endfunction

    assign bus.phase  = phase_q;
    assign bus.commit = (phase_q == LAST_PHASE) && !bus.stall;
    assign bus.pc     = {regs[PC_HI_IDX], regs[PC_HI_IDX+1]};
    assign bus.flags  = regs[FLAG_IDX];

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [IW-1:0] idx;
        assign idx = bus.rd_idx[p*IW +: IW];
        assign bus.rd_data[p*REG_W +: REG_W] = in_range(idx) ? regs[idx] : '0;
    end

    assign pair_hi_byte = in_range(bus.pair_hi) ? regs[bus.pair_hi] : '0;
    assign pair_lo_byte = in_range(bus.pair_lo) ? regs[bus.pair_lo] : '0;
    assign pair_in      = {pair_hi_byte, pair_lo_byte};
    assign bus.pair_out = pair_out;

    always_comb begin
        case (bus.pair_op)
            2'd1, 2'd3: pair_out = pair_in + PW'(1);
            2'd2:       pair_out = pair_in - PW'(1);
            default:    pair_out = pair_in;
        endcase
    end

    // Writers applied lowest priority first so later sources overwrite earlier ones per byte.
    always_comb begin
        nxt = regs;
        if (bus.wr_en && in_range(bus.wr_idx))
            nxt[bus.wr_idx] = bus.wr_data;
        if (bus.pair_op == 2'd1 || bus.pair_op == 2'd2) begin
            if (in_range(bus.pair_hi)) nxt[bus.pair_hi] = pair_out[PW-1:REG_W];
            if (in_range(bus.pair_lo)) nxt[bus.pair_lo] = pair_out[REG_W-1:0];
        end
        case (bus.pc_op)
            2'd1: begin
                nxt[PC_HI_IDX]   = pair_out[PW-1:REG_W];
                nxt[PC_HI_IDX+1] = pair_out[REG_W-1:0];
            end
            2'd2: begin
                nxt[PC_HI_IDX]   = bus.pc_load[PW-1:REG_W];
                nxt[PC_HI_IDX+1] = bus.pc_load[REG_W-1:0];
            end
            default: ;
        endcase
        if (bus.flag_en)
            nxt[FLAG_IDX] = bus.flag_data;
        // Unwritable flag bits read as zero whatever the source.
        nxt[FLAG_IDX] = nxt[FLAG_IDX] & FLAG_MASK;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALS[i*REG_W +: REG_W];
`ifdef REGFILE_SNAPSHOT_EN
                shadow[i] <= RESET_VALS[i*REG_W +: REG_W];
`endif
            end
        end else begin
            if (!bus.stall)
                phase_q <= (phase_q == LAST_PHASE) ? '0 : phase_q + PHW'(1);
            if (bus.commit) begin
`ifdef REGFILE_SNAPSHOT_EN
                // Shadow captures the normal post-commit image even when a restore overrides it.
                if (bus.snap_save)
                    shadow <= nxt;
                if (bus.snap_restore)
                    regs <= shadow;
                else
                    regs <= nxt;
`else
                regs <= nxt;
`endif
            end
        end
    end
endmodule

// File: tb/tb_cpu_regfile_seq.sv
// Directed bench for cpu_regfile_seq: reset image, sequencer, pair unit, write priority and reset abort.
// Build with REGFILE_SNAPSHOT_EN to also cover the shadow bank.
module tb_cpu_regfile_seq;
    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cpu_regfile_seq_if #(.NUM_REGS(14), .REG_W(8), .RD_PORTS(2), .PHASES(4)) bus ();

    cpu_regfile_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.stall     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_idx    = 4'd0;
        bus.wr_data   = 8'h00;
        bus.pair_op   = 2'd0;
        bus.pair_hi   = 4'd0;
        bus.pair_lo   = 4'd0;
        bus.pc_op     = 2'd0;
        bus.pc_load   = 16'h0000;
        bus.flag_en   = 1'b0;
        bus.flag_data = 8'h00;
`ifdef REGFILE_SNAPSHOT_EN
        bus.snap_save    = 1'b0;
        bus.snap_restore = 1'b0;
`endif
    endtask

    task automatic set_rd(input logic [3:0] p0, input logic [3:0] p1);
        bus.rd_idx = {p1, p0};
        #1;
    endtask

    // Entered and left on a negedge at phase 0; inputs held for one whole M-cycle.
    task automatic commit_cycle();
        repeat (4) @(negedge clk);
        idle();
    endtask

    task automatic wr(input logic [3:0] idx, input logic [7:0] dat);
        bus.wr_en = 1'b1; bus.wr_idx = idx; bus.wr_data = dat;
    endtask

    logic [1:0] exp_phase [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       exp_cmt   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        idle();
        set_rd(4'd9, 4'd1);
        #12;
        check("rst_pc_async", bus.pc, 16'h0100);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_pc", bus.pc, 16'h0100);
        check("rst_flags", 16'(bus.flags), 16'h00B0);
        check("rst_rd9", 16'(bus.rd_data[7:0]), 16'h00FE);
        check("rst_rd1", 16'(bus.rd_data[15:8]), 16'h0013);
        check("rst_phase", 16'(bus.phase), 16'h0000);
        check("rst_commit", 16'(bus.commit), 16'h0000);

        // Sequencer with stall over clocks 2-3.
        for (int k = 0; k < 8; k++) begin
            bus.stall = (k == 2 || k == 3);
            #1;
            check($sformatf("phase_%0d", k), 16'(bus.phase), 16'(exp_phase[k]));
            check($sformatf("commit_%0d", k), 16'(bus.commit), 16'(exp_cmt[k]));
            @(negedge clk);
        end
        bus.stall = 1'b0;
        repeat (2) @(negedge clk);
        check("phase_realign", 16'(bus.phase), 16'h0000);

        // Write lands only on the commit edge.
        wr(4'd9, 8'hFF);
        set_rd(4'd9, 4'd8);
        repeat (3) @(negedge clk);
        check("wr_precommit", 16'(bus.rd_data[7:0]), 16'h00FE);
        @(negedge clk);
        idle();
        #1;
        check("wr_commit", 16'(bus.rd_data[7:0]), 16'h00FF);

        // Pair 8/9 = 0xFFFF: inc wraps, dec wraps back, inc-no-writeback leaves it.
        bus.pair_op = 2'd1; bus.pair_hi = 4'd8; bus.pair_lo = 4'd9;
        #1;
        check("pair_inc_out", bus.pair_out, 16'h0000);
        commit_cycle();
        set_rd(4'd8, 4'd9);
        check("pair_inc_hi", 16'(bus.rd_data[7:0]), 16'h0000);
        check("pair_inc_lo", 16'(bus.rd_data[15:8]), 16'h0000);
        bus.pair_op = 2'd2; bus.pair_hi = 4'd8; bus.pair_lo = 4'd9;
        #1;
        check("pair_dec_out", bus.pair_out, 16'h0000 - 16'h0001);
        commit_cycle();
        #1;
        check("pair_dec_val", {bus.rd_data[7:0], bus.rd_data[15:8]}, 16'hFFFF);
        bus.pair_op = 2'd3; bus.pair_hi = 4'd8; bus.pair_lo = 4'd9;
        #1;
        check("pair_nowb_out", bus.pair_out, 16'h0000);
        commit_cycle();
        #1;
        check("pair_nowb_val", {bus.rd_data[7:0], bus.rd_data[15:8]}, 16'hFFFF);

        // Flags: flag_en beats the write port, masking applies to both.
        wr(4'd6, 8'hFF);
        bus.flag_en = 1'b1; bus.flag_data = 8'h5A;
        commit_cycle();
        #1;
        check("flag_collide", 16'(bus.flags), 16'h0050);
        wr(4'd6, 8'hFF);
        commit_cycle();
        set_rd(4'd6, 4'd7);
        check("flag_mask_wr", 16'(bus.rd_data[7:0]), 16'h00F0);

        // PC load beats pair writeback on the PC pair; then PC from the incrementer.
        bus.pc_op = 2'd2; bus.pc_load = 16'h0038;
        bus.pair_op = 2'd1; bus.pair_hi = 4'd12; bus.pair_lo = 4'd13;
        #1;
        check("pc_pair_pre", bus.pair_out, 16'h0101);
        commit_cycle();
        #1;
        check("pc_load", bus.pc, 16'h0038);
        bus.pc_op = 2'd1; bus.pair_op = 2'd3; bus.pair_hi = 4'd12; bus.pair_lo = 4'd13;
        commit_cycle();
        #1;
        check("pc_from_pair", bus.pc, 16'h0039);

        // Pair writeback beats the write port on reg 0.
        wr(4'd0, 8'h55);
        bus.pair_op = 2'd1; bus.pair_hi = 4'd0; bus.pair_lo = 4'd1;
        commit_cycle();
        set_rd(4'd0, 4'd1);
        check("prio_pair_hi", 16'(bus.rd_data[7:0]), 16'h0000);
        check("prio_pair_lo", 16'(bus.rd_data[15:8]), 16'h0014);

        // Out-of-range indices.
        set_rd(4'd14, 4'd15);
        check("rd_oor14", 16'(bus.rd_data[7:0]), 16'h0000);
        check("rd_oor15", 16'(bus.rd_data[15:8]), 16'h0000);
        wr(4'd15, 8'h77);
        commit_cycle();
        wr(4'd14, 8'h66);
        commit_cycle();
        set_rd(4'd13, 4'd0);
        check("wr_oor_r13", 16'(bus.rd_data[7:0]), 16'h0039);
        check("wr_oor_r0", 16'(bus.rd_data[15:8]), 16'h0000);

        // Stall at phase 3 suppresses commit until released.
        wr(4'd2, 8'hAA);
        set_rd(4'd2, 4'd3);
        repeat (3) @(negedge clk);
        bus.stall = 1'b1;
        #1;
        check("stall_commit", 16'(bus.commit), 16'h0000);
        repeat (2) @(negedge clk);
        check("stall_phase", 16'(bus.phase), 16'h0003);
        check("stall_noupd", 16'(bus.rd_data[7:0]), 16'h0000);
        bus.stall = 1'b0;
        #1;
        check("stall_release", 16'(bus.commit), 16'h0001);
        @(negedge clk);
        idle();
        #1;
        check("stall_upd", 16'(bus.rd_data[7:0]), 16'h00AA);
        check("stall_phase0", 16'(bus.phase), 16'h0000);

`ifdef REGFILE_SNAPSHOT_EN
        // Save A=0x12, overwrite, restore; then save+restore together.
        set_rd(4'd7, 4'd0);
        wr(4'd7, 8'h12); bus.snap_save = 1'b1;
        commit_cycle();
        wr(4'd7, 8'h99);
        commit_cycle();
        #1;
        check("snap_a_new", 16'(bus.rd_data[7:0]), 16'h0099);
        bus.snap_restore = 1'b1;
        commit_cycle();
        #1;
        check("snap_restore", 16'(bus.rd_data[7:0]), 16'h0012);
        wr(4'd7, 8'h44); bus.snap_save = 1'b1; bus.snap_restore = 1'b1;
        commit_cycle();
        #1;
        check("snap_both_reg", 16'(bus.rd_data[7:0]), 16'h0012);
        bus.snap_restore = 1'b1;
        commit_cycle();
        #1;
        check("snap_both_shadow", 16'(bus.rd_data[7:0]), 16'h0044);
`endif

        // Reset at phase 2 aborts the pending write.
        wr(4'd3, 8'h11);
        set_rd(4'd3, 4'd9);
        repeat (2) @(negedge clk);
        check("mid_phase2", 16'(bus.phase), 16'h0002);
        reset_n = 1'b0;
        #1;
        check("mid_rst_phase", 16'(bus.phase), 16'h0000);
        check("mid_rst_pc", bus.pc, 16'h0100);
        check("mid_rst_flags", 16'(bus.flags), 16'h00B0);
        check("mid_rst_r9", 16'(bus.rd_data[15:8]), 16'h00FE);
        @(negedge clk);
        idle();
        reset_n = 1'b1;
        commit_cycle();
        #1;
        check("mid_rst_r3", 16'(bus.rd_data[7:0]), 16'h00D8);
`ifdef REGFILE_SNAPSHOT_EN
        bus.snap_restore = 1'b1;
        set_rd(4'd7, 4'd0);
        commit_cycle();
        #1;
        check("mid_rst_shadow", 16'(bus.rd_data[7:0]), 16'h0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
